// File: rtl/mx_pkg.sv
// Shared types and helpers for MX element normalisation.
// Struct typedefs here are sized for the default 8-bit/3-bit element configuration.
package mx_pkg;

  function automatic int clog2_p1(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int DEF_WIDTH_I = 8;
  localparam int DEF_MAN_W   = 3;
  localparam int DEF_LZ_W    = $clog2(DEF_WIDTH_I + 1);
  localparam int DEF_EXP_W   = clog2_p1(DEF_WIDTH_I);

  typedef struct packed {
    logic                   valid;
    logic                   sign;
    logic [DEF_WIDTH_I-1:0] mag;
    logic [DEF_LZ_W-1:0]    lz;
  } norm_s1_t;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [DEF_EXP_W-1:0] exp;
    logic [DEF_MAN_W-1:0] man;
    logic                 zero;
  } norm_s2_t;

endpackage

// File: rtl/clz_int.sv
// Count leading zeros of an unsigned value; an all-zero input returns width.
module clz_int #(
  parameter int width = 8,
  parameter int lz_w  = $clog2(width + 1)
) (
  input  logic [width-1:0] value,
  output logic [lz_w-1:0]  lz
);

  // Scan upward so the highest set bit is the last one to write lz.
  always_comb begin
    lz = lz_w'(width);
    for (int i = 0; i < width; i++) begin
      if (value[i]) lz = lz_w'(width - 1 - i);
    end
  end

endmodule

// File: rtl/int_norm_pipe.sv
// Two-stage valid/ready pipeline turning a signed integer into sign/exponent/mantissa.
// Build option: define NORM_ROUND_EN for round-to-nearest-even on the fraction (default truncates).
module int_norm_pipe
  import mx_pkg::*;
#(
  parameter int width_i = 8,
  parameter int man_w   = 3,
  parameter int exp_w   = clog2_p1(width_i)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [width_i-1:0] i_num,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_sign,
  output logic [exp_w-1:0]   o_exp,
  output logic [man_w-1:0]   o_man,
  output logic               o_zero
);

  localparam int lz_w = $clog2(width_i + 1);

  typedef struct packed {
    logic               valid;
    logic               sign;
    logic [width_i-1:0] mag;
    logic [lz_w-1:0]    lz;
  } s1_reg_t;

  typedef struct packed {
    logic             valid;
    logic             sign;
    logic [exp_w-1:0] exp;
    logic [man_w-1:0] man;
    logic             zero;
  } s2_reg_t;

  s1_reg_t s1_q;
  s2_reg_t s2_q;

  logic               en;
  logic               in_sign;
  logic [width_i-1:0] in_mag;
  logic [lz_w-1:0]    in_lz;

  // The whole pipe advances together; a stalled output freezes stage 1 as well.
  assign en      = !s2_q.valid || i_ready;
  assign o_ready = en;

  // Negating the most negative value wraps back to 2^(width_i-1), which is the correct magnitude.
  assign in_sign = i_num[width_i-1];
  assign in_mag  = in_sign ? -i_num : i_num;

  clz_int #(
    .width(width_i),
    .lz_w (lz_w)
  ) u_clz (
    .value(in_mag),
    .lz   (in_lz)
  );

  logic [width_i-1:0] sh;
  logic [man_w-1:0]   frac;
  logic [exp_w-1:0]   exp_base;
  logic               is_zero;
  logic [exp_w-1:0]   s2_exp;
  logic [man_w-1:0]   s2_man;
  logic               unused_sh;

  assign sh        = s1_q.mag << s1_q.lz;
  assign frac      = sh[width_i-2 -: man_w];
  assign is_zero   = (s1_q.mag == '0);
  assign exp_base  = is_zero ? '0 : exp_w'(width_i - 1 - int'(s1_q.lz));
  assign unused_sh = ^sh;

`ifdef NORM_ROUND_EN
  logic [width_i-1:0] rest;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [man_w:0]     frac_sum;

  // Bits below the fraction, top-aligned: guard is the MSB, sticky the OR of the others.
  assign rest     = sh << (man_w + 1);
  assign guard    = rest[width_i-1];
  assign sticky   = |rest[width_i-2:0];
  assign round_up = guard && (sticky || frac[0]);
  assign frac_sum = {1'b0, frac} + (man_w + 1)'(round_up);
  assign s2_man   = frac_sum[man_w-1:0];
  assign s2_exp   = exp_base + exp_w'(frac_sum[man_w]);
`else
  assign s2_man   = frac;
  assign s2_exp   = exp_base;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (en) begin
      s1_q.valid <= i_valid;
      s1_q.sign  <= in_sign;
      s1_q.mag   <= in_mag;
      s1_q.lz    <= in_lz;
      s2_q.valid <= s1_q.valid;
      s2_q.sign  <= s1_q.sign && !is_zero;
      s2_q.exp   <= s2_exp;
      s2_q.man   <= s2_man;
      s2_q.zero  <= is_zero;
    end
  end

  assign o_valid = s2_q.valid;
  assign o_sign  = s2_q.sign;
  assign o_exp   = s2_q.exp;
  assign o_man   = s2_q.man;
  assign o_zero  = s2_q.zero;

endmodule

// File: tb/tb_int_norm_pipe.sv
// Self-checking bench for int_norm_pipe: vector table through a scoreboard, plus stall and flush sequences.
// Expectations follow NORM_ROUND_EN when the bench is built with it.
module tb_int_norm_pipe;

  localparam int width_i = 8;
  localparam int man_w   = 3;
  localparam int exp_w   = 4;
`ifdef NORM_ROUND_EN
  localparam bit rnd = 1'b1;
`else
  localparam bit rnd = 1'b0;
`endif

  logic               i_clk;
  logic               i_rst;
  logic               i_valid;
  logic               o_ready;
  logic [width_i-1:0] i_num;
  logic               o_valid;
  logic               i_ready;
  logic               o_sign;
  logic [exp_w-1:0]   o_exp;
  logic [man_w-1:0]   o_man;
  logic               o_zero;

  int_norm_pipe #(
    .width_i(width_i),
    .man_w  (man_w),
    .exp_w  (exp_w)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_num  (i_num),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sign (o_sign),
    .o_exp  (o_exp),
    .o_man  (o_man),
    .o_zero (o_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [width_i-1:0] num;
    logic               sign;
    logic [exp_w-1:0]   exp;
    logic [man_w-1:0]   man;
    logic               zero;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_popped = 0;

  function automatic vec_t mk(int num, bit s, int e, int m, bit z);
    vec_t v;
    v.num  = width_i'(num);
    v.sign = s;
    v.exp  = exp_w'(e);
    v.man  = man_w'(m);
    v.zero = z;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Every output beat is compared against the scoreboard head, repeatedly while it is held.
  task automatic checkOutput();
    vec_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("[TB] FAIL unexpected_beat: got exp=%0d man=%0h, expected no beat", o_exp, o_man);
    end else begin
      e = sb_q[0];
      check($sformatf("beat_%0d", $signed(e.num)),
            32'({o_sign, o_exp, o_man, o_zero}),
            32'({e.sign, e.exp, e.man, e.zero}));
      if (i_ready) begin
        void'(sb_q.pop_front());
        n_popped++;
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_valid) checkOutput();
  end

  task automatic applyStimulus(input vec_t v);
    bit accepted;
    accepted = 1'b0;
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_num   = v.num;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge i_clk);
      if (o_ready) accepted = 1'b1;
    end
    if (accepted) sb_q.push_back(v);
    else begin
      n_checks++;
      $display("[TB] FAIL accept_timeout: got o_ready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic goIdle();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && sb_q.size() != 0; c++) @(negedge i_clk);
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int popped_before;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_num   = '0;
    i_ready = 1'b1;

    tbl.push_back(mk(1,    0, 0, 0, 0));
    tbl.push_back(mk(-128, 1, 7, 0, 0));
    tbl.push_back(mk(0,    0, 0, 0, 1));
    tbl.push_back(mk(-1,   1, 0, 0, 0));
    tbl.push_back(mk(92,   0, 6, rnd ? 4 : 3, 0));
    tbl.push_back(mk(127,  0, rnd ? 7 : 6, rnd ? 0 : 7, 0));
    tbl.push_back(mk(-92,  1, 6, rnd ? 4 : 3, 0));
    tbl.push_back(mk(5,    0, 2, 2, 0));
    tbl.push_back(mk(-3,   1, 1, 4, 0));
    tbl.push_back(mk(100,  0, 6, 4, 0));
    tbl.push_back(mk(101,  0, 6, rnd ? 5 : 4, 0));
    tbl.push_back(mk(-127, 1, rnd ? 7 : 6, rnd ? 0 : 7, 0));
    tbl.push_back(mk(64,   0, 6, 0, 0));

    #1;
    check("reset_outputs", 32'({o_valid, o_sign, o_exp, o_man, o_zero}), 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_ready", 32'(o_ready), 32'd1);
    i_rst = 1'b0;

    $display("[TB] vector table, unstalled");
    foreach (tbl[i]) applyStimulus(tbl[i]);
    goIdle();
    drain();

    $display("[TB] stream 1,2,3,4 with a three-cycle output stall");
    fork
      begin
        applyStimulus(mk(1, 0, 0, 0, 0));
        applyStimulus(mk(2, 0, 1, 0, 0));
        applyStimulus(mk(3, 0, 1, 4, 0));
        applyStimulus(mk(4, 0, 2, 0, 0));
        goIdle();
      end
      begin
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge i_clk);
          check($sformatf("stall_valid_ready_%0d", c), 32'({o_valid, o_ready}), 32'b10);
          @(posedge i_clk);
        end
        #1;
        i_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] flush two beats in flight with reset");
    applyStimulus(mk(5, 0, 2, 2, 0));
    applyStimulus(mk(-3, 1, 1, 4, 0));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_rst   = 1'b1;
    sb_q.delete();
    #1;
    check("flush_immediate", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    check("flush_held", 32'(o_valid), 32'd0);
    i_rst = 1'b0;
    popped_before = n_popped;
    applyStimulus(mk(64, 0, 6, 0, 0));
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    check("latency_cycle1", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    #1;
    check("latency_cycle2", 32'(o_valid), 32'd1);
    drain();
    check("single_beat_after_flush", 32'(n_popped - popped_before), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
